// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

    // Hazard controller states
    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

    localparam int REG_AW_DEF = 5;

endpackage

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall, memory-wait freeze and branch flush control (optional HAZARD_STATS_EN stall counter)
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              branch_taken,
    input  logic              exmem_mem_access,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              hazard_mux,
    output logic              ifid_flush,
    output logic              pipe_hold
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dep;
    logic             mem_wait;

    // $zero never carries a real dependency; rt only matters when the ID instruction reads it
    assign dep = idex_mem_read && (idex_rt != '0) &&
                 ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign mem_wait = exmem_mem_access && !mem_ready;

    // Prioritised enable/flush decode and next-state logic; outputs are same-cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        hazard_mux = 1'b0;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            hazard_mux = 1'b1;
        end else if (mem_wait) begin
            // Whole pipe frozen: stall bookkeeping must not advance
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            // Taken branch kills the ID instruction and aborts any pending load-use stall
            ifid_flush = 1'b1;
            hazard_mux = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
        end else if (state_q == LU_STALL) begin
            // ID/EX holds a bubble here, so dep is not looked at again
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            hazard_mux = 1'b1;
            cnt_d      = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = RUN;
            end
        end else if (dep) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            hazard_mux = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LU_STALL;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    // State and remaining-bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles spent inserting load-use bubbles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_mux && !ifid_flush && !mem_wait && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // Statistics register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_stat_w;
    assign unused_stat_w = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - randomized and directed check of hazard_ctrl_unit against a cycle-level model
module tb_hazard_ctrl_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          idex_mem_read;
    logic [AW-1:0] idex_rt;
    logic [AW-1:0] ifid_rs;
    logic [AW-1:0] ifid_rt;
    logic          ifid_uses_rt;
    logic          branch_taken;
    logic          exmem_mem_access;
    logic          mem_ready;

    logic pc1, ifw1, hm1, fl1, ph1;
    logic pc3, ifw3, hm3, fl3, ph3;
`ifdef HAZARD_STATS_EN
    logic [1:0] sc1, sc3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rem1 = 0, rem3 = 0;
    int st1 = 0, st3 = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(1), .STAT_W(2)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .exmem_mem_access(exmem_mem_access), .mem_ready(mem_ready),
        .pc_write(pc1), .ifid_write(ifw1), .hazard_mux(hm1), .ifid_flush(fl1), .pipe_hold(ph1)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(sc1)
`endif
    );

    hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(3), .STAT_W(2)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .exmem_mem_access(exmem_mem_access), .mem_ready(mem_ready),
        .pc_write(pc3), .ifid_write(ifw3), .hazard_mux(hm3), .ifid_flush(fl3), .pipe_hold(ph3)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(sc3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rem = bubbles still owed after this cycle's decision.
    // Output vector order: {pc_write, ifid_write, hazard_mux, ifid_flush, pipe_hold}
    task automatic model_eval(input int lat, input int rem, output logic [4:0] o,
                              output int rem_n, output bit stalled);
        bit dep, mw;
        dep = idex_mem_read && (idex_rt != 0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        mw = exmem_mem_access && !mem_ready;
        rem_n   = rem;
        stalled = 1'b0;
        if (!rst_n) begin
            o = 5'b00100; rem_n = 0;
        end else if (mw) begin
            o = 5'b00001;
        end else if (branch_taken) begin
            o = 5'b11110; rem_n = 0;
        end else if (rem > 0) begin
            o = 5'b00100; rem_n = rem - 1; stalled = 1'b1;
        end else if (dep) begin
            o = 5'b00100; rem_n = lat - 1; stalled = 1'b1;
        end else begin
            o = 5'b11000;
        end
    endtask

    task automatic drive(input bit mr, input int irt, input int rs, input int rt, input bit ur,
                         input bit br, input bit acc, input bit rdy);
        idex_mem_read    = mr;
        idex_rt          = AW'(irt);
        ifid_rs          = AW'(rs);
        ifid_rt          = AW'(rt);
        ifid_uses_rt     = ur;
        branch_taken     = br;
        exmem_mem_access = acc;
        mem_ready        = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Called 1 time unit after a rising edge with inputs already applied
    task automatic step(input string tag);
        logic [4:0] e1, e3;
        int r1n, r3n;
        bit s1, s3;
        #4;
        if (!rst_n) begin
            rem1 = 0; rem3 = 0; st1 = 0; st3 = 0;
        end
        model_eval(1, rem1, e1, r1n, s1);
        model_eval(3, rem3, e3, r3n, s3);
        check({tag, "/lat1"}, {27'd0, pc1, ifw1, hm1, fl1, ph1}, {27'd0, e1});
        check({tag, "/lat3"}, {27'd0, pc3, ifw3, hm3, fl3, ph3}, {27'd0, e3});
`ifdef HAZARD_STATS_EN
        check({tag, "/stat1"}, {30'd0, sc1}, st1);
        check({tag, "/stat3"}, {30'd0, sc3}, st3);
`endif
        @(posedge clk);
        if (rst_n) begin
            rem1 = r1n;
            rem3 = r3n;
            if (s1 && st1 < 3) st1++;
            if (s3 && st3 < 3) st3++;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk); #1;
        step("reset0");
        step("reset1");
        rst_n = 1'b1;
        step("run0");

        // Single-bubble load-use on rs
        drive(1, 5, 5, 0, 0, 0, 0, 1); step("lu_rs");
        idle(); step("lu_after0"); step("lu_after1"); step("lu_after2");

        // No stall on $zero, nor on rt that is not read
        drive(1, 0, 0, 0, 1, 0, 0, 1); step("zero_reg");
        drive(1, 7, 1, 7, 0, 0, 0, 1); step("rt_unused");
        drive(1, 7, 1, 7, 1, 0, 0, 1); step("rt_used");
        idle(); step("rt_after0"); step("rt_after1"); step("rt_after2");

        // Memory wait during the second stall cycle
        drive(1, 5, 5, 0, 0, 0, 0, 1); step("mw_s1");
        drive(0, 0, 0, 0, 0, 0, 1, 0); step("mw_w1"); step("mw_w2");
        idle(); step("mw_s2"); step("mw_s3"); step("mw_run");

        // Taken branch aborts a multi-cycle stall
        drive(1, 9, 2, 9, 1, 0, 0, 1); step("br_s1");
        drive(0, 0, 0, 0, 0, 1, 0, 1); step("br_flush");
        idle(); step("br_run0"); step("br_run1");

        // Reset in the middle of a stall
        drive(1, 4, 4, 0, 0, 0, 0, 1); step("rs_s1");
        idle(); rst_n = 1'b0; step("rs_in_reset");
        rst_n = 1'b1; step("rs_first"); step("rs_second");

        // Random traffic over a small register set to make dependencies common
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
